// File: rtl/fpu_add_arbiter_if.sv
// Request/response/adder bundle for fpu_add_arbiter.
// The slave view belongs to the arbiter. The master view belongs to whoever
// drives the requests and hosts the external adder.
interface fpu_add_arbiter_if #(
  parameter int unsigned NREQ = 4
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*32-1:0] req_a;
  logic [NREQ*32-1:0] req_b;
  logic [NREQ-1:0]    req_sub;
  logic [NREQ-1:0]    resp_valid;
  logic [NREQ-1:0]    resp_ready;
  logic [NREQ*32-1:0] resp_data;
  logic [31:0]        fpu_a;
  logic [31:0]        fpu_b;
  logic               fpu_sub;
  logic [31:0]        fpu_s;
  logic               idle;
  logic [31:0]        issue_count;

  modport slave (
    input  req_valid, req_a, req_b, req_sub, resp_ready, fpu_s,
    output req_ready, resp_valid, resp_data, fpu_a, fpu_b, fpu_sub, idle, issue_count
  );

  modport master (
    output req_valid, req_a, req_b, req_sub, resp_ready, fpu_s,
    input  req_ready, resp_valid, resp_data, fpu_a, fpu_b, fpu_sub, idle, issue_count
  );
endinterface

// File: rtl/fpu_add_arbiter.sv
// Round-robin sharing of one external FP add/sub unit among NREQ requesters.
// Each requester may have one operation outstanding. A tag pipe as deep as
// the adder latency routes each result to the one-entry holding register of
// the requester that issued it.
module fpu_add_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned ADD_LAT = 1
) (
  input logic              clk,
  input logic              rst,
  fpu_add_arbiter_if.slave bus
);

  localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Registered state
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0] inflight_q, inflight_d;
  logic [NREQ-1:0] resp_valid_q, resp_valid_d;
  logic [31:0]     resp_data_q [NREQ];
  logic [31:0]     resp_data_d [NREQ];
  logic [31:0]     issue_count_q, issue_count_d;
  logic [ADD_LAT-1:0] tag_vld_q, tag_vld_d;
  logic [IDW-1:0]  tag_id_q [ADD_LAT];
  logic [IDW-1:0]  tag_id_d [ADD_LAT];

  // Arbitration
  logic [NREQ-1:0] busy;
  logic [NREQ-1:0] elig;
  logic            gnt_vld;
  logic [IDW-1:0]  gnt_idx;
  logic [NREQ-1:0] gnt_oh;

  // Retire side: the tag leaving the pipe lines up with fpu_s
  logic            ret_vld;
  logic [IDW-1:0]  ret_id;

  // Adder drive
  logic [31:0]        fpu_a_mux;
  logic [31:0]        fpu_b_mux;
  logic               fpu_sub_mux;
  logic [NREQ*32-1:0] resp_data_flat;

  // Busy only looks at registered state, so a freed slot re-arms one cycle later
  assign busy    = inflight_q | resp_valid_q;
  assign elig    = bus.req_valid & ~busy;
  assign ret_vld = tag_vld_q[ADD_LAT-1];
  assign ret_id  = tag_id_q[ADD_LAT-1];

  // Round-robin scan: first eligible requester starting at rr_ptr
  always_comb begin
    int unsigned idx;
    idx     = 0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(rr_ptr_q) + k) % NREQ;
      if (!gnt_vld && elig[IDW'(idx)]) begin
        gnt_vld = 1'b1;
        gnt_idx = IDW'(idx);
      end
    end
  end

  // One-hot grant and operand select for the winner; zeros when nothing issues
  always_comb begin
    gnt_oh      = '0;
    fpu_a_mux   = '0;
    fpu_b_mux   = '0;
    fpu_sub_mux = 1'b0;
    if (gnt_vld) begin
      gnt_oh[gnt_idx] = 1'b1;
    end
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt_vld && (gnt_idx == IDW'(i))) begin
        fpu_a_mux   = bus.req_a[32*i +: 32];
        fpu_b_mux   = bus.req_b[32*i +: 32];
        fpu_sub_mux = bus.req_sub[i];
      end
    end
  end

  // Next state: pointer advance, tag shift, retire capture, response drain
  always_comb begin
    rr_ptr_d      = rr_ptr_q;
    inflight_d    = inflight_q;
    resp_valid_d  = resp_valid_q & ~bus.resp_ready;
    resp_data_d   = resp_data_q;
    issue_count_d = issue_count_q;
    tag_vld_d     = '0;
    for (int unsigned s = 0; s < ADD_LAT; s++) begin
      tag_id_d[s] = '0;
    end

    // Tag pipe: stage 0 takes the new issue (or a bubble), the rest shift along
    tag_vld_d[0] = gnt_vld;
    tag_id_d[0]  = gnt_idx;
    for (int unsigned s = 1; s < ADD_LAT; s++) begin
      tag_vld_d[s] = tag_vld_q[s-1];
      tag_id_d[s]  = tag_id_q[s-1];
    end

    // A retiring requester holds no response, so the drain above cannot collide
    if (ret_vld) begin
      resp_data_d[ret_id]  = bus.fpu_s;
      resp_valid_d[ret_id] = 1'b1;
      inflight_d[ret_id]   = 1'b0;
    end

    // The winner is never busy, so it cannot be the requester retiring now
    if (gnt_vld) begin
      inflight_d[gnt_idx] = 1'b1;
      rr_ptr_d            = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
      issue_count_d       = issue_count_q + 32'd1;
    end
  end

  // State registers with synchronous reset; reset drops all in-flight tags
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q      <= '0;
      inflight_q    <= '0;
      resp_valid_q  <= '0;
      issue_count_q <= '0;
      tag_vld_q     <= '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
        resp_data_q[i] <= '0;
      end
      for (int unsigned s = 0; s < ADD_LAT; s++) begin
        tag_id_q[s] <= '0;
      end
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      inflight_q    <= inflight_d;
      resp_valid_q  <= resp_valid_d;
      issue_count_q <= issue_count_d;
      tag_vld_q     <= tag_vld_d;
      resp_data_q   <= resp_data_d;
      tag_id_q      <= tag_id_d;
    end
  end

  // Flatten the holding registers onto the packed response bus
  always_comb begin
    resp_data_flat = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      resp_data_flat[32*i +: 32] = resp_data_q[i];
    end
  end

  assign bus.req_ready   = gnt_oh;
  assign bus.fpu_a       = fpu_a_mux;
  assign bus.fpu_b       = fpu_b_mux;
  assign bus.fpu_sub     = fpu_sub_mux;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_data   = resp_data_flat;
  assign bus.issue_count = issue_count_q;
  assign bus.idle        = ~(|inflight_q) & ~(|resp_valid_q);

  a_grant_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_oh));
  a_grant_not_busy: assert property (@(posedge clk) disable iff (rst)
    gnt_vld |-> !busy[gnt_idx]);
  a_retire_inflight: assert property (@(posedge clk) disable iff (rst)
    ret_vld |-> inflight_q[ret_id]);

endmodule

// File: tb/tb_fpu_add_arbiter.sv
// Bench for fpu_add_arbiter: directed scenarios plus a per-cycle reference
// model. The model keeps per-requester busy flags and response due-times
// instead of a tag pipe.
module tb_fpu_add_arbiter;
  localparam int NREQ    = 4;
  localparam int ADD_LAT = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fpu_add_arbiter_if #(.NREQ(NREQ)) bus ();

  fpu_add_arbiter #(.NREQ(NREQ), .ADD_LAT(ADD_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Stand-in adder: exact IEEE results for the operand pairs used here,
  // otherwise an arbitrary mix (the arbiter only routes the word)
  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b,
                                       input logic sub);
    case ({sub, a, b})
      {1'b0, 32'h3F800000, 32'h40000000}: return 32'h40400000; // 1+2
      {1'b1, 32'h40400000, 32'h3F800000}: return 32'h40000000; // 3-1
      {1'b0, 32'h40000000, 32'h40000000}: return 32'h40800000; // 2+2
      {1'b0, 32'h3F800000, 32'h3F800000}: return 32'h40000000; // 1+1
      {1'b1, 32'h40A00000, 32'h40000000}: return 32'h40400000; // 5-2
      {1'b0, 32'h3F000000, 32'h3F000000}: return 32'h3F800000; // .5+.5
      default: return a ^ {b[15:0], b[31:16]} ^ {31'd0, sub};
    endcase
  endfunction

  logic [31:0] apipe [ADD_LAT];
  always @(posedge clk) begin
    apipe[0] <= fadd(bus.fpu_a, bus.fpu_b, bus.fpu_sub);
    for (int s = 1; s < ADD_LAT; s++) apipe[s] <= apipe[s-1];
  end
  assign bus.fpu_s = apipe[ADD_LAT-1];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model state, at reset values
  int          cyc = 0;
  int          m_rr = 0;
  bit          m_busy [NREQ];
  int          m_due [NREQ];
  logic [31:0] m_pend [NREQ];
  logic [31:0] m_last [NREQ];
  logic [31:0] m_cnt = 32'd0;

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      m_busy[i] = 1'b0;
      m_due[i]  = 0;
      m_pend[i] = '0;
      m_last[i] = '0;
    end
  end

  // Compare every cycle at the falling edge, then advance the model
  always @(negedge clk) begin : model_cmp
    int                 g;
    int                 idx;
    logic [NREQ-1:0]    e_rdy;
    logic [NREQ-1:0]    e_rv;
    logic [NREQ*32-1:0] e_data;
    logic [31:0]        ea;
    logic [31:0]        eb;
    logic               es;
    logic               e_idle;
    cyc++;
    e_rv   = '0;
    e_data = '0;
    e_idle = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      if (m_busy[i] && cyc == m_due[i]) m_last[i] = m_pend[i];
      e_rv[i] = m_busy[i] && (cyc >= m_due[i]);
      e_data[i*32 +: 32] = m_last[i];
      if (m_busy[i]) e_idle = 1'b0;
    end
    g = -1;
    for (int k = 0; k < NREQ; k++) begin
      idx = (m_rr + k) % NREQ;
      if (g < 0 && bus.req_valid[idx] && !m_busy[idx]) g = idx;
    end
    e_rdy = '0;
    ea    = '0;
    eb    = '0;
    es    = 1'b0;
    if (g >= 0) begin
      e_rdy[g] = 1'b1;
      ea = bus.req_a[g*32 +: 32];
      eb = bus.req_b[g*32 +: 32];
      es = bus.req_sub[g];
    end
    chk("m_req_ready", bus.req_ready, e_rdy);
    chk("m_fpu_a", bus.fpu_a, ea);
    chk("m_fpu_b", bus.fpu_b, eb);
    chk("m_fpu_sub", bus.fpu_sub, es);
    chk("m_resp_valid", bus.resp_valid, e_rv);
    chk("m_resp_data", bus.resp_data, e_data);
    chk("m_idle", bus.idle, e_idle);
    chk("m_issue_count", bus.issue_count, m_cnt);
    if (rst) begin
      m_rr  = 0;
      m_cnt = '0;
      for (int i = 0; i < NREQ; i++) begin
        m_busy[i] = 1'b0;
        m_last[i] = '0;
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (e_rv[i] && bus.resp_ready[i]) m_busy[i] = 1'b0;
      end
      if (g >= 0) begin
        m_busy[g] = 1'b1;
        m_due[g]  = cyc + ADD_LAT + 1;
        m_pend[g] = fadd(ea, eb, es);
        m_rr      = (g + 1) % NREQ;
        m_cnt     = m_cnt + 32'd1;
      end
    end
  end

  // Requesters drop valid after a handshake unless marked sticky
  logic [NREQ-1:0] hs_n   = '0;
  logic [NREQ-1:0] sticky = '0;
  always @(negedge clk) hs_n = bus.req_valid & bus.req_ready;

  task automatic tick();
    @(posedge clk);
    #1;
    bus.req_valid = bus.req_valid & ~(hs_n & ~sticky);
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic sub);
    bus.req_a[i*32 +: 32] = a;
    bus.req_b[i*32 +: 32] = b;
    bus.req_sub[i]        = sub;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_rv(input int i, input int budget);
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (bus.resp_valid[i]) return;
      tick();
    end
    @(negedge clk);
  endtask

  task automatic wait_idle(input string name);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.idle) break;
      tick();
    end
    chk(name, bus.idle, 1'b1);
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int  others;
    bit  seen1;
    bus.req_valid  = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.req_sub    = '0;
    bus.resp_ready = '1;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_idle", bus.idle, 1'b1);
    chk("reset_count", bus.issue_count, 32'd0);
    chk("reset_rv", bus.resp_valid, 4'b0000);

    // T1 single add
    tick();
    set_req(0, 32'h3F800000, 32'h40000000, 1'b0);
    bus.req_valid[0] = 1'b1;
    @(negedge clk);
    chk("t1_grant", bus.req_ready, 4'b0001);
    chk("t1_fpu_a", bus.fpu_a, 32'h3F800000);
    chk("t1_fpu_b", bus.fpu_b, 32'h40000000);
    tick();
    @(negedge clk);
    chk("t1_rv_early", bus.resp_valid[0], 1'b0);
    tick();
    @(negedge clk);
    chk("t1_rv", bus.resp_valid[0], 1'b1);
    chk("t1_data", bus.resp_data[31:0], 32'h40400000);
    tick();
    @(negedge clk);
    chk("t1_idle", bus.idle, 1'b1);

    // T2 subtract on requester 2
    tick();
    set_req(2, 32'h40400000, 32'h3F800000, 1'b1);
    bus.req_valid[2] = 1'b1;
    wait_rv(2, 8);
    chk("t2_rv", bus.resp_valid[2], 1'b1);
    chk("t2_data", bus.resp_data[95:64], 32'h40000000);
    tick();
    wait_idle("t2_idle");

    // T3 all four from reset
    do_reset();
    set_req(0, 32'h40000000, 32'h40000000, 1'b0);
    set_req(1, 32'h3F800000, 32'h3F800000, 1'b0);
    set_req(2, 32'h40A00000, 32'h40000000, 1'b1);
    set_req(3, 32'h3F000000, 32'h3F000000, 1'b0);
    bus.req_valid = 4'b1111;
    @(negedge clk);
    chk("t3_g0", bus.req_ready, 4'b0001);
    tick();
    @(negedge clk);
    chk("t3_g1", bus.req_ready, 4'b0010);
    tick();
    @(negedge clk);
    chk("t3_g2", bus.req_ready, 4'b0100);
    tick();
    @(negedge clk);
    chk("t3_g3", bus.req_ready, 4'b1000);
    tick();
    tick();
    tick();
    @(negedge clk);
    chk("t3_count", bus.issue_count, 32'd4);
    chk("t3_data", bus.resp_data,
        {32'h3F800000, 32'h40400000, 32'h40000000, 32'h40800000});

    // T4 backpressure on requester 1
    tick();
    set_req(1, 32'h40000000, 32'h40000000, 1'b0);
    sticky         = 4'b1111;
    bus.resp_ready = 4'b1101;
    bus.req_valid  = 4'b1111;
    others = 0;
    seen1  = 1'b0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (bus.resp_valid[1]) begin
        seen1 = 1'b1;
        chk("t4_no_regrant", bus.req_ready[1], 1'b0);
        chk("t4_hold", bus.resp_data[63:32], 32'h40800000);
      end
      if ((bus.req_ready & bus.req_valid & 4'b1101) != 4'b0000) others++;
      tick();
    end
    chk("t4_seen1", seen1, 1'b1);
    chk("t4_others", others >= 8, 1'b1);
    bus.resp_ready = 4'b1111;
    sticky         = 4'b0000;
    bus.req_valid  = 4'b0010;
    @(negedge clk);
    chk("t4_release_cycle", bus.req_ready, 4'b0000);
    tick();
    @(negedge clk);
    chk("t4_regrant", bus.req_ready, 4'b0010);
    tick();
    wait_idle("t4_idle");

    // T5 reset with ops in flight and responses held
    do_reset();
    bus.resp_ready = 4'b0000;
    bus.req_valid  = 4'b0111;
    @(negedge clk);
    tick();
    @(negedge clk);
    tick();
    @(negedge clk);
    tick();
    rst = 1'b1;
    bus.req_valid = '0;
    @(negedge clk);
    tick();
    rst = 1'b0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("t5_no_resp", bus.resp_valid, 4'b0000);
      tick();
    end
    @(negedge clk);
    chk("t5_count", bus.issue_count, 32'd0);
    chk("t5_data", bus.resp_data, 128'd0);
    tick();
    bus.resp_ready = 4'b1111;
    bus.req_valid  = 4'b1010;
    @(negedge clk);
    chk("t5_rr", bus.req_ready, 4'b0010);
    tick();
    wait_idle("t5_idle");
    bus.req_valid = '0;
    wait_idle("t5_idle2");

    // T6 issue counter wrap
    force dut.issue_count_q = 32'hFFFFFFFF;
    m_cnt = 32'hFFFFFFFF;
    @(negedge clk);
    #1;
    release dut.issue_count_q;
    tick();
    @(negedge clk);
    chk("t6_preload", bus.issue_count, 32'hFFFFFFFF);
    tick();
    set_req(0, 32'h3F800000, 32'h40000000, 1'b0);
    bus.req_valid[0] = 1'b1;
    @(negedge clk);
    tick();
    @(negedge clk);
    chk("t6_wrap", bus.issue_count, 32'd0);
    tick();
    wait_idle("t6_idle");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
